spike_rate_decoder: RTL

Receive end of the spiking network's output interface: converts per-channel spike trains, such as the layer-2 neuron spikes, back into numeric firing rates. It counts spikes per channel over a programmable window and latches the counts plus a winner-take-all index at the end of each window. Results are handed to a consumer over a valid/ready handshake. It sits downstream of the spike network, between the spike outputs and any readout or host logic.

---
 rtl/spike_rate_decoder_pkg.sv | 21 ++
 rtl/spike_rate_decoder_counter.sv | 35 +++
 rtl/spike_rate_decoder.sv | 124 ++++++++++++
 3 files changed

// File: rtl/spike_rate_decoder_pkg.sv
// rtl/spike_rate_decoder_pkg.sv - shared constants and saturating-add helper for the spike rate decoder
package spike_rate_decoder_pkg;

    localparam int NCH_DEF   = 2;
    localparam int CNT_W_DEF = 8;
    localparam int WIN_W_DEF = 8;
    localparam int IDX_W_DEF = 3;

    localparam logic [31:0] CNT_MAX_DEF = (32'd1 << CNT_W_DEF) - 32'd1;

    // Adds a single spike bit to a count, pinning the result at max.
    function automatic logic [31:0] sat_add(input logic [31:0] a,
                                            input logic        b,
                                            input logic [31:0] max);
        if (b && (a < max)) begin
            return a + 32'd1;
        end
        return a;
    endfunction

endpackage

// File: rtl/spike_rate_decoder_counter.sv
// rtl/spike_rate_decoder_counter.sv - per-channel saturating spike counter
module spike_counter_sat
    import spike_rate_decoder_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             spike,
    output logic [CNT_W-1:0] count
);

    localparam logic [31:0] MAX = (32'd1 << CNT_W) - 32'd1;

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic [31:0]      sum_full;
    logic [31-CNT_W:0] sum_unused;

    // count already includes this cycle's spike so the window's last cycle can latch it directly
    assign sum_full   = sat_add(32'(count_q), spike, MAX);
    assign count      = sum_full[CNT_W-1:0];
    assign sum_unused = sum_full[31:CNT_W];
    assign count_d    = clr ? '0 : count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/spike_rate_decoder.sv
// rtl/spike_rate_decoder.sv - windowed per-channel spike rate counter with winner-take-all and valid/ready output
module spike_rate_decoder
    import spike_rate_decoder_pkg::*;
#(
    parameter int NCH   = NCH_DEF,
    parameter int CNT_W = CNT_W_DEF,
    parameter int WIN_W = WIN_W_DEF,
    parameter int IDX_W = IDX_W_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 enable,
    input  logic [NCH-1:0]       spike_in,
    input  logic [WIN_W-1:0]     window_len,
    output logic [NCH*CNT_W-1:0] rate_out,
    output logic [IDX_W-1:0]     winner,
    output logic                 any_spike,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 overrun
);

    logic [WIN_W-1:0]     win_cnt_q, win_cnt_d;
    logic [WIN_W-1:0]     len_q, len_d;
    logic [WIN_W-1:0]     eff_len;
    logic                 first_cycle;
    logic                 last_cycle;
    logic                 clr;
    logic                 accept;

    logic [CNT_W-1:0]     fin [NCH];
    logic [CNT_W-1:0]     best;
    logic [IDX_W-1:0]     win_idx;
    logic                 any_nz;

    logic [NCH*CNT_W-1:0] rate_q, rate_d;
    logic [IDX_W-1:0]     winner_q, winner_d;
    logic                 any_q, any_d;
    logic                 valid_q, valid_d;
    logic                 overrun_q, overrun_d;

    // On cycle 0 the live window_len governs, so L=1 can close the window in the same cycle it opens.
    assign first_cycle = (win_cnt_q == '0);
    assign eff_len     = !first_cycle ? len_q :
                         (window_len == '0) ? WIN_W'(1) : window_len;
    assign last_cycle  = enable && (win_cnt_q == (eff_len - WIN_W'(1)));
    assign clr         = !enable || last_cycle;
    assign accept      = valid_q && out_ready;

    assign len_d     = first_cycle ? eff_len : len_q;
    assign win_cnt_d = clr ? '0 : (win_cnt_q + WIN_W'(1));

    for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
        spike_counter_sat #(.CNT_W(CNT_W)) u_cnt (
            .clk   (clk),
            .rst_n (rst_n),
            .clr   (clr),
            .spike (spike_in[gi]),
            .count (fin[gi])
        );
    end

    // Strict greater-than keeps the lowest index on ties.
    always_comb begin
        best    = fin[0];
        win_idx = '0;
        any_nz  = 1'b0;
        for (int i = 0; i < NCH; i++) begin
            if (fin[i] != '0) begin
                any_nz = 1'b1;
            end
            if (fin[i] > best) begin
                best    = fin[i];
                win_idx = IDX_W'(i);
            end
        end
    end

    always_comb begin
        rate_d    = rate_q;
        winner_d  = winner_q;
        any_d     = any_q;
        valid_d   = valid_q;
        overrun_d = overrun_q;
        if (last_cycle) begin
            for (int i = 0; i < NCH; i++) begin
                rate_d[i*CNT_W +: CNT_W] = fin[i];
            end
            winner_d  = win_idx;
            any_d     = any_nz;
            valid_d   = 1'b1;
            overrun_d = overrun_q || (valid_q && !out_ready);
        end else if (accept) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_cnt_q <= '0;
            len_q     <= '0;
            rate_q    <= '0;
            winner_q  <= '0;
            any_q     <= 1'b0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            win_cnt_q <= win_cnt_d;
            len_q     <= len_d;
            rate_q    <= rate_d;
            winner_q  <= winner_d;
            any_q     <= any_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
        end
    end

    assign rate_out  = rate_q;
    assign winner    = winner_q;
    assign any_spike = any_q;
    assign out_valid = valid_q;
    assign overrun   = overrun_q;

endmodule
